contador_seq: RTL
=================

CONTADOR_SEQ -- requirements
Module: contador_seq

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accept; high only in IDLE.
REQ-006 cmd_start  in  8  value to load into the counter.
REQ-007 cmd_target  in  8  value at which counting stops.
REQ-008 pause  in  1  freezes counting while high.
REQ-009 abort  in  1  cancels the active command.
REQ-010 cnt_value  in  8  counter output (counter_out) fed back.
REQ-011 cnt_load  out  1  counter loads cnt_entrada on the next edge.
REQ-012 cnt_entrada  out  8  load value to the counter.
REQ-013 cnt_key  out  1  direction: 1 up, 0 down.
REQ-014 cnt_run  out  1  counter steps one count per edge when high and cnt_load is low; holds otherwise.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse when the target is reached.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, RUN and DONE.
REQ-018 IDLE: cmd_ready=1; cmd_valid=1 at an edge latches start and target, sets the direction (key=1 if target>=start, else 0), and moves to LOAD.
REQ-019 LOAD: cnt_load=1 and cnt_entrada=start for exactly one cycle, then move to RUN.
REQ-020 RUN: cnt_run=!pause && (cnt_value!=target), combinational, so the counter never passes the target.
REQ-021 RUN: cnt_value==target at an edge moves the FSM to DONE.
REQ-022 DONE: done=1 for one cycle, then move to IDLE.
REQ-023 Latency from the acceptance edge: LOAD takes 1 cycle, RUN takes |target-start|+1 cycles plus the paused cycles, DONE takes 1 cycle.
REQ-024 start==target: RUN lasts one cycle with cnt_run=0, then DONE.
REQ-025 Direction is fixed toward the target, so counter wrap-around never occurs.
REQ-026 cmd_valid while busy SHALL be ignored, with no latch and no side effect.
REQ-027 abort in LOAD or RUN SHALL return the FSM to IDLE at the next edge with no done pulse; cnt_run and cnt_load are forced to 0 in the abort cycle.
REQ-028 abort in IDLE or DONE SHALL have no effect.
REQ-029 When reset and abort are high together, reset takes precedence.
REQ-030 cnt_key SHALL hold the latched direction from LOAD until the next command.
REQ-031 cnt_entrada SHALL hold the latched start value outside LOAD.

Reset
REQ-032 Reset SHALL force IDLE, with cmd_ready=1, busy=0, done=0, cnt_load=0, cnt_run=0, cnt_key=1, cnt_entrada=0, and clear the latched start and target to 0.
REQ-033 Reset during LOAD or RUN SHALL abandon the command at that edge with no done pulse.

Configuration
REQ-034 With CONTADOR_SEQ_CYCLES_EN defined, the block SHALL add the output run_cycles (16 bits).
REQ-035 run_cycles SHALL be cleared at command acceptance and by reset.
REQ-036 run_cycles SHALL increment on each edge in RUN where cnt_run=1, saturating at 16'hFFFF.
REQ-037 run_cycles SHALL hold its value after DONE or abort.
REQ-038 Without CONTADOR_SEQ_CYCLES_EN, the run_cycles port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-039 Up count: start=9, target=12 -> cnt_load for 1 cycle with entrada=9, key=1, 3 cnt_run cycles, cnt_value=12, done 6 cycles after acceptance; run_cycles=3 with the macro.
REQ-040 Down count: start=20, target=15 -> key=0, 5 cnt_run cycles, cnt_value=15, single done pulse.
REQ-041 Equal values: start=target=7 -> LOAD, one RUN cycle with cnt_run=0, done; cnt_value=7.
REQ-042 Pause: start=0, target=4, pause high for 3 cycles mid-RUN -> cnt_run=0 and cnt_value held during the pause, done 3 cycles later than without the pause.
REQ-043 Abort and reset: abort at cnt_value=2 in a 0->10 command -> IDLE next edge, no done, cnt_value stays 2; reset mid-RUN -> all outputs at their reset values next edge.
REQ-044 Busy rejection: a second cmd_valid during RUN -> ignored; first command completes with its original target.

Source files
------------

// File: rtl/contador_seq.sv
// Command sequencer driving an external up/down counter from start to target.
// Optional CONTADOR_SEQ_CYCLES_EN adds a saturating run_cycles counter output.
module contador_seq (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_start,
    input  logic [7:0] cmd_target,
    input  logic       pause,
    input  logic       abort,
    input  logic [7:0] cnt_value,
    output logic       cnt_load,
    output logic [7:0] cnt_entrada,
    output logic       cnt_key,
    output logic       cnt_run,
    output logic       busy,
    output logic       done
`ifdef CONTADOR_SEQ_CYCLES_EN
    ,
    output logic [15:0] run_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state, state_next;
    logic [7:0] start_q;
    logic [7:0] target_q;
    logic       key_q;
    logic       accept;
    logic       at_target;

    assign accept    = (state == IDLE) && cmd_valid;
    assign at_target = (cnt_value == target_q);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            start_q  <= 8'd0;
            target_q <= 8'd0;
            key_q    <= 1'b1;
        end else begin
            state <= state_next;
            if (accept) begin
                start_q  <= cmd_start;
                target_q <= cmd_target;
                key_q    <= (cmd_target >= cmd_start);
            end
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_run    = 1'b0;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_next = LOAD;
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    cnt_load   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                // Gating on at_target keeps the counter from ever stepping past the target.
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    cnt_run = !pause && !at_target;
                    if (at_target) state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign cnt_entrada = start_q;
    assign cnt_key     = key_q;

`ifdef CONTADOR_SEQ_CYCLES_EN
    always_ff @(posedge clock) begin
        if (reset || accept) begin
            run_cycles <= 16'd0;
        end else if (cnt_run && (run_cycles != 16'hFFFF)) begin
            run_cycles <= run_cycles + 16'd1;
        end
    end
`endif

endmodule
